// File: rtl/n1_pkg.sv
// Shared constants, loader state encoding and the ui_in packing helper for the
// n1 program loader.
package n1_pkg;

  localparam int RAM_BYTES_DEFAULT = 128;
  localparam int ADDR_BITS_DEFAULT = $clog2(RAM_BYTES_DEFAULT);
  localparam int WR_EN_BIT         = 7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_CHECK,
    ST_RUN,
    ST_FAIL
  } loader_state_t;

  // Bit WR_EN_BIT carries the write strobe; the address sits in the low bits.
  function automatic logic [7:0] packUi(input logic wrEn, input logic [WR_EN_BIT-1:0] addr);
    logic [7:0] v;
    v = '0;
    v[WR_EN_BIT] = wrEn;
    v[WR_EN_BIT-1:0] = addr;
    return v;
  endfunction

endpackage

// File: rtl/n1_img_checksum.sv
// Running mod-256 sum and xor over a byte stream; one instance checks what was
// written, another checks what was read back.
module n1_img_checksum (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_clr,
  input  logic       i_en,
  input  logic [7:0] i_byte,
  output logic [7:0] o_sum,
  output logic [7:0] o_xor
);

  logic [7:0] r_sum;
  logic [7:0] r_xor;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sum <= '0;
      r_xor <= '0;
    end else if (i_clr) begin
      r_sum <= '0;
      r_xor <= '0;
    end else if (i_en) begin
      r_sum <= r_sum + i_byte;
      r_xor <= r_xor ^ i_byte;
    end
  end

  assign o_sum = r_sum;
  assign o_xor = r_xor;

endmodule

// File: rtl/n1_prog_loader.sv
// Host-side loader for the n1 reset-time program port: writes an image into the
// target RAM, reads it back, and releases the target only if the checksums agree.
module n1_prog_loader
  import n1_pkg::*;
#(
  parameter int RAM_BYTES = RAM_BYTES_DEFAULT,
  parameter int ADDR_BITS = $clog2(RAM_BYTES)
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic [ADDR_BITS:0] i_img_len,
  input  logic               i_img_valid,
  input  logic [7:0]         i_img_data,
  output logic               o_img_ready,
  output logic               o_tgt_rst_n,
  output logic [7:0]         o_tgt_ui_in,
  output logic [7:0]         o_tgt_uio_in,
  input  logic [7:0]         i_tgt_uo_out,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_err
);

  localparam logic [ADDR_BITS:0] LEN_MAX = (ADDR_BITS+1)'(RAM_BYTES);
  localparam logic [ADDR_BITS:0] ONE     = (ADDR_BITS+1)'(1);

  loader_state_t      r_state, w_stateNext;
  logic [ADDR_BITS:0] r_len, w_lenNext;
  logic [ADDR_BITS:0] r_addr, w_addrNext;
  logic [7:0]         r_tgtUi, w_tgtUiNext;
  logic [7:0]         r_tgtUio, w_tgtUioNext;
  logic               r_tgtRstN, w_tgtRstNNext;
  logic               r_imgReady, w_imgReadyNext;
  logic               r_busy, w_busyNext;
  logic               r_done, w_doneNext;
  logic               r_err, w_errNext;
  logic [1:0]         r_rdVld, w_rdVldNext;

  logic               w_startAcc, w_beat, w_lastBeat, w_issue, w_rdFold, w_match;
  logic [ADDR_BITS:0] w_lenMin;
  logic [7:0]         w_wrSum, w_wrXor, w_rdSum, w_rdXor;

  assign w_startAcc = i_start && (r_state == ST_IDLE || r_state == ST_RUN || r_state == ST_FAIL);
  assign w_lenMin   = (i_img_len > LEN_MAX) ? LEN_MAX : i_img_len;
  assign w_beat     = (r_state == ST_WRITE) && r_imgReady && i_img_valid;
  assign w_lastBeat = w_beat && (r_addr == r_len - ONE);
  assign w_issue    = (r_state == ST_READ) && (r_addr != r_len);
  assign w_rdFold   = (r_state == ST_READ) && r_rdVld[1];
  assign w_match    = (w_rdSum == w_wrSum) && (w_rdXor == w_wrXor);

  // Readback counter runs to len; only addresses below len reach the pins.
  always_comb begin
    w_stateNext    = r_state;
    w_lenNext      = r_len;
    w_addrNext     = r_addr;
    w_tgtUiNext    = r_tgtUi;
    w_tgtUioNext   = r_tgtUio;
    w_tgtRstNNext  = r_tgtRstN;
    w_imgReadyNext = r_imgReady;
    w_busyNext     = r_busy;
    w_doneNext     = r_done;
    w_errNext      = r_err;
    w_rdVldNext    = r_rdVld;
    case (r_state)
      ST_IDLE, ST_RUN, ST_FAIL: begin
        if (w_startAcc) begin
          w_stateNext    = ST_WRITE;
          w_lenNext      = w_lenMin;
          w_addrNext     = '0;
          w_tgtUiNext    = '0;
          w_tgtRstNNext  = 1'b0;
          w_imgReadyNext = (w_lenMin != '0);
          w_busyNext     = 1'b1;
          w_doneNext     = 1'b0;
          w_errNext      = 1'b0;
          w_rdVldNext    = '0;
        end
      end
      ST_WRITE: begin
        if (r_len == '0) begin
          w_stateNext   = ST_RUN;
          w_tgtRstNNext = 1'b1;
          w_doneNext    = 1'b1;
          w_busyNext    = 1'b0;
        end else if (w_beat) begin
          w_tgtUiNext  = packUi(1'b1, 7'(r_addr[ADDR_BITS-1:0]));
          w_tgtUioNext = i_img_data;
          if (w_lastBeat) begin
            w_imgReadyNext = 1'b0;
            w_addrNext     = '0;
            w_stateNext    = ST_READ;
          end else begin
            w_addrNext = r_addr + ONE;
          end
        end else begin
          w_tgtUiNext[WR_EN_BIT] = 1'b0;
        end
      end
      ST_READ: begin
        w_tgtUiNext[WR_EN_BIT] = 1'b0;
        if (w_issue) begin
          w_tgtUiNext = packUi(1'b0, 7'(r_addr[ADDR_BITS-1:0]));
          w_addrNext  = r_addr + ONE;
        end
        w_rdVldNext = {r_rdVld[0], w_issue};
        if (!w_issue && !r_rdVld[0] && r_rdVld[1]) begin
          w_stateNext = ST_CHECK;
        end
      end
      ST_CHECK: begin
        w_busyNext = 1'b0;
        if (w_match) begin
          w_stateNext   = ST_RUN;
          w_tgtUiNext   = '0;
          w_tgtRstNNext = 1'b1;
          w_doneNext    = 1'b1;
        end else begin
          w_stateNext = ST_FAIL;
          w_errNext   = 1'b1;
        end
      end
      default: w_stateNext = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_IDLE;
      r_len      <= '0;
      r_addr     <= '0;
      r_tgtUi    <= '0;
      r_tgtUio   <= '0;
      r_tgtRstN  <= 1'b0;
      r_imgReady <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_rdVld    <= '0;
    end else begin
      r_state    <= w_stateNext;
      r_len      <= w_lenNext;
      r_addr     <= w_addrNext;
      r_tgtUi    <= w_tgtUiNext;
      r_tgtUio   <= w_tgtUioNext;
      r_tgtRstN  <= w_tgtRstNNext;
      r_imgReady <= w_imgReadyNext;
      r_busy     <= w_busyNext;
      r_done     <= w_doneNext;
      r_err      <= w_errNext;
      r_rdVld    <= w_rdVldNext;
    end
  end

  n1_img_checksum u_wrSum (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (w_startAcc),
    .i_en    (w_beat),
    .i_byte  (i_img_data),
    .o_sum   (w_wrSum),
    .o_xor   (w_wrXor)
  );

  n1_img_checksum u_rdSum (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (w_startAcc),
    .i_en    (w_rdFold),
    .i_byte  (i_tgt_uo_out),
    .o_sum   (w_rdSum),
    .o_xor   (w_rdXor)
  );

  assign o_img_ready  = r_imgReady;
  assign o_tgt_rst_n  = r_tgtRstN;
  assign o_tgt_ui_in  = r_tgtUi;
  assign o_tgt_uio_in = r_tgtUio;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_err        = r_err;

endmodule
